// File: rtl/lock_servo_driver.sv
// rtl/lock_servo_driver.sv - door-lock servo latch driver: 50 Hz PWM with ramped open/close and timed auto-relock
// Pulse width only moves at frame ends so every PWM frame carries exactly one complete pulse.
module lock_servo_driver #(
  parameter int unsigned PERIOD  = 1_000_000,
  parameter int unsigned PW_LOCK = 50_000,
  parameter int unsigned PW_OPEN = 100_000,
  parameter int unsigned STEP    = 5_000,
  parameter int unsigned HOLD    = 250_000_000,
  parameter int unsigned CW      = 28
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          unlock,
  input  logic          relock,
  output logic          servo_pwm,
  output logic [1:0]    state,
  output logic [CW-1:0] pw,
  output logic          opened
);

  typedef enum logic [1:0] {
    ST_LOCKED  = 2'b00,
    ST_OPENING = 2'b01,
    ST_OPEN    = 2'b10,
    ST_CLOSING = 2'b11
  } state_t;

  localparam logic [CW-1:0] LP_FC_LAST   = CW'(PERIOD - 1);
  localparam logic [CW-1:0] LP_HOLD_LAST = CW'(HOLD - 1);
  localparam logic [CW-1:0] LP_PW_LOCK   = CW'(PW_LOCK);
  localparam logic [CW-1:0] LP_PW_OPEN   = CW'(PW_OPEN);
  localparam logic [CW-1:0] LP_STEP      = CW'(STEP);

  state_t        r_state;
  state_t        w_state_nx;
  logic [CW-1:0] r_fc;
  logic [CW-1:0] r_hold;
  logic [CW-1:0] w_hold_nx;
  logic [CW-1:0] r_pw;
  logic [CW-1:0] w_pw_nx;
  logic [CW-1:0] w_pw_up;
  logic [CW-1:0] w_pw_dn;
  logic          r_unlock_d;
  logic          r_opened;
  logic          w_opened_nx;
  logic          w_rise;
  logic          w_frame_end;

  assign w_rise      = unlock & ~r_unlock_d;
  assign w_frame_end = (r_fc == LP_FC_LAST);
  assign w_pw_up     = r_pw + LP_STEP;
  assign w_pw_dn     = r_pw - LP_STEP;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_fc <= '0;
    end else if (w_frame_end) begin
      r_fc <= '0;
    end else begin
      r_fc <= r_fc + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state    <= ST_LOCKED;
      r_pw       <= LP_PW_LOCK;
      r_hold     <= '0;
      r_unlock_d <= 1'b0;
      r_opened   <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_pw       <= w_pw_nx;
      r_hold     <= w_hold_nx;
      r_unlock_d <= unlock;
      r_opened   <= w_opened_nx;
    end
  end

  // relock has priority over a rise everywhere; a ramp already at its limit finishes without stepping
  always_comb begin
    w_state_nx  = r_state;
    w_pw_nx     = r_pw;
    w_hold_nx   = '0;
    w_opened_nx = 1'b0;
    case (r_state)
      ST_LOCKED: begin
        if (w_rise && !relock) begin
          w_state_nx = ST_OPENING;
        end
      end
      ST_OPENING: begin
        if (relock) begin
          w_state_nx = ST_CLOSING;
        end else if (r_pw == LP_PW_OPEN) begin
          w_state_nx  = ST_OPEN;
          w_opened_nx = 1'b1;
        end else if (w_frame_end) begin
          w_pw_nx = w_pw_up;
          if (w_pw_up == LP_PW_OPEN) begin
            w_state_nx  = ST_OPEN;
            w_opened_nx = 1'b1;
          end
        end
      end
      ST_OPEN: begin
        if (relock) begin
          w_state_nx = ST_CLOSING;
        end else if (w_rise) begin
          w_hold_nx = '0;
        end else if (r_hold == LP_HOLD_LAST) begin
          w_state_nx = ST_CLOSING;
        end else begin
          w_hold_nx = r_hold + 1'b1;
        end
      end
      ST_CLOSING: begin
        if (w_rise && !relock) begin
          w_state_nx = ST_OPENING;
        end else if (r_pw == LP_PW_LOCK) begin
          w_state_nx = ST_LOCKED;
        end else if (w_frame_end) begin
          w_pw_nx = w_pw_dn;
          if (w_pw_dn == LP_PW_LOCK) begin
            w_state_nx = ST_LOCKED;
          end
        end
      end
      default: begin
        w_state_nx = ST_LOCKED;
        w_pw_nx    = LP_PW_LOCK;
      end
    endcase
  end

  assign servo_pwm = (r_fc < r_pw);
  assign state     = r_state;
  assign pw        = r_pw;
  assign opened    = r_opened;

endmodule

// File: tb/tb_lock_servo_driver.sv
// tb/tb_lock_servo_driver.sv - scoreboard bench for lock_servo_driver against a cycle-level behavioural model
module tb_lock_servo_driver;

  localparam int PERIOD  = 100;
  localparam int PW_LOCK = 10;
  localparam int PW_OPEN = 30;
  localparam int STEP    = 5;
  localparam int HOLD    = 200;
  localparam int CW      = 16;

  logic          clock  = 1'b0;
  logic          resetn = 1'b0;
  logic          unlock = 1'b0;
  logic          relock = 1'b0;
  logic          servo_pwm;
  logic [1:0]    state;
  logic [CW-1:0] pw;
  logic          opened;

  lock_servo_driver #(
    .PERIOD(PERIOD), .PW_LOCK(PW_LOCK), .PW_OPEN(PW_OPEN),
    .STEP(STEP), .HOLD(HOLD), .CW(CW)
  ) dut (
    .clock(clock), .resetn(resetn), .unlock(unlock), .relock(relock),
    .servo_pwm(servo_pwm), .state(state), .pw(pw), .opened(opened)
  );

  always #5 clock = ~clock;

  typedef struct {
    int st;
    int pw;
    int pwm;
    int op;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int pwm_hi = 0;

  // model: 0 locked, 1 opening, 2 open, 3 closing
  int m_state = 0;
  int m_pw = PW_LOCK;
  int m_fc = 0;
  int m_hold = 0;
  int m_prev_unlock = 0;
  int m_opened = 0;

  task automatic chk(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, want);
    end
  endtask

  task automatic bound_chk(input string name, input bit ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s at t=%0t: condition not reached within cycle budget", name, $time);
    end
  endtask

  task automatic model_step(input int rn, input int u, input int rl);
    int rise;
    int at_end;
    int was_open;
    if (rn == 0) begin
      m_state = 0; m_pw = PW_LOCK; m_fc = 0; m_hold = 0;
      m_prev_unlock = 0; m_opened = 0;
      return;
    end
    rise     = (u == 1 && m_prev_unlock == 0) ? 1 : 0;
    at_end   = (m_fc == PERIOD - 1) ? 1 : 0;
    was_open = (m_state == 2) ? 1 : 0;
    if (m_state == 0) begin
      if (rise == 1 && rl == 0) m_state = 1;
    end else if (m_state == 1) begin
      if (rl == 1) m_state = 3;
      else if (m_pw == PW_OPEN) m_state = 2;
      else if (at_end == 1) begin
        m_pw = m_pw + STEP;
        if (m_pw == PW_OPEN) m_state = 2;
      end
      if (m_state == 2) m_hold = 0;
    end else if (m_state == 2) begin
      if (rl == 1) m_state = 3;
      else if (rise == 1) m_hold = 0;
      else if (m_hold == HOLD - 1) m_state = 3;
      else m_hold = m_hold + 1;
    end else begin
      if (rise == 1 && rl == 0) m_state = 1;
      else if (m_pw == PW_LOCK) m_state = 0;
      else if (at_end == 1) begin
        m_pw = m_pw - STEP;
        if (m_pw == PW_LOCK) m_state = 0;
      end
    end
    m_opened      = (m_state == 2 && was_open == 0) ? 1 : 0;
    m_fc          = (m_fc + 1) % PERIOD;
    m_prev_unlock = u;
  endtask

  task automatic cyc(input int rn, input int u, input int rl);
    exp_t e;
    @(negedge clock);
    pwm_hi += int'(servo_pwm);
    resetn = rn[0];
    unlock = u[0];
    relock = rl[0];
    model_step(rn, u, rl);
    e.st  = m_state;
    e.pw  = m_pw;
    e.pwm = (m_fc < m_pw) ? 1 : 0;
    e.op  = m_opened;
    q.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("state", int'(state), e.st);
        chk("pw", int'(pw), e.pw);
        chk("servo_pwm", int'(servo_pwm), e.pwm);
        chk("opened", int'(opened), e.op);
      end
    end
  end

  initial begin
    int u;
    repeat (3) cyc(0, 0, 0);

    pwm_hi = 0;
    repeat (300) cyc(1, 0, 0);
    chk("idle_pwm_high_cycles", pwm_hi, 30);

    for (int k = 0; k < 200 && m_fc != 50; k++) cyc(1, 0, 0);
    bound_chk("align_fc50", m_fc == 50);
    repeat (1500) cyc(1, 1, 0);

    cyc(1, 0, 0);
    for (int k = 0; k < 1000 && m_state != 2; k++) cyc(1, 1, 0);
    bound_chk("reach_open_for_relock", m_state == 2);
    repeat (49) cyc(1, 1, 0);
    cyc(1, 1, 1);

    for (int k = 0; k < 1000 && !(m_state == 3 && m_pw == 20); k++) cyc(1, 0, 0);
    bound_chk("reach_closing_pw20", m_state == 3 && m_pw == 20);
    cyc(1, 1, 0);
    for (int k = 0; k < 1000 && m_state != 2; k++) cyc(1, 1, 0);
    bound_chk("reopen_from_closing", m_state == 2);
    for (int k = 0; k < 300 && m_hold != 100; k++) cyc(1, 0, 0);
    bound_chk("reach_hold100", m_hold == 100);
    repeat (700) cyc(1, 1, 0);

    cyc(1, 0, 0);
    for (int k = 0; k < 1000 && !(m_state == 1 && m_pw == 20); k++) cyc(1, 1, 0);
    bound_chk("reach_opening_pw20", m_state == 1 && m_pw == 20);
    cyc(1, 0, 0);
    cyc(1, 1, 1);
    repeat (500) cyc(1, 1, 0);

    cyc(1, 0, 0);
    for (int k = 0; k < 1000 && !(m_state == 1 && m_pw == 20); k++) cyc(1, 1, 0);
    bound_chk("reach_opening_pw20_rst", m_state == 1 && m_pw == 20);
    cyc(0, 1, 0);
    repeat (200) cyc(1, 1, 0);

    u = 0;
    for (int k = 0; k < 20000; k++) begin
      if ($urandom_range(0, 199) == 0) u = 1 - u;
      cyc(($urandom_range(0, 4999) == 0) ? 0 : 1, u,
          ($urandom_range(0, 299) == 0) ? 1 : 0);
    end
    repeat (5) cyc(1, 0, 0);

    for (int k = 0; k < 20 && q.size() > 0; k++) begin
      @(posedge clock);
      #2;
    end
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
